midi_avalon_bridge: RTL and testbench
=====================================

MIDI_AVALON_BRIDGE -- requirements
Module: midi_avalon_bridge

Interface
REQ-001 Parameter CHANNEL, default 0, is the MIDI channel (0-15) accepted when OMNI=0.
REQ-002 Parameter OMNI, default 0; when 1, channel messages on all channels are accepted.
REQ-003 Parameter FIFO_DEPTH, default 4, is the command FIFO depth; it is a power of two, at least 2.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  is the synchronous, active-high reset.
REQ-006 in_data  input  8  is the MIDI byte from the UART receiver.
REQ-007 in_valid  input  1  means in_data is valid this cycle.
REQ-008 in_ready  output  1  means the bridge accepts in_data this cycle; a byte is consumed when in_valid & in_ready.
REQ-009 avm_m0_write  output  1  is the Avalon-MM master write request to synthesizer_top.
REQ-010 avm_m0_writedata  output  32  is the synth command {16'b0, on, note[6:0], vel[7:0]}.
REQ-011 avm_m0_waitrequest  input  1  is the slave stall; while high, the current write is not taken.

Function
REQ-012 Bytes 0xF8-0xFF (real-time) SHALL be consumed and ignored, with no change to parser state.
REQ-013 Bytes 0xF0-0xF7 SHALL clear running status, and the parser SHALL go to IDLE.
REQ-014 Parser states are IDLE, DATA1 and DATA2, with a running-status register {valid, type, channel-match}.
REQ-015 A status byte 0x80-0xEF SHALL load running status and enter DATA1 from any state, aborting a partial message.
REQ-016 In IDLE, a data byte (bit7=0) with no running status SHALL be discarded; with running status, it is treated as the first data byte.
REQ-017 Types 0x8,0x9,0xA,0xB,0xE are two-data-byte messages; types 0xC,0xD are one-data-byte messages; after the last data byte, the parser returns to DATA1 (running status).
REQ-018 Note-on (0x9n, vel>0) SHALL produce command on=1, note=d1, vel={1'b0,d2}.
REQ-019 Note-off (0x8n), or note-on with vel=0, SHALL produce command on=0, note=d1, vel={1'b0,d2}; note-off for note 127 SHALL be dropped, so no false STOP_ALL is sent.
REQ-020 Control change 0xBn with d1=123 (all notes off) SHALL produce STOP_ALL = 0x0000_7F00; all other CC, 0xA, 0xC, 0xD and 0xE messages SHALL be consumed silently.
REQ-021 Messages whose channel fails the filter SHALL be consumed but produce no command.
REQ-022 A command SHALL be pushed into the FIFO on the same edge its final data byte is consumed.
REQ-023 in_ready SHALL equal !fifo_full, which is a registered signal; a push therefore always has space.
REQ-024 avm_m0_write SHALL equal !fifo_empty, and avm_m0_writedata SHALL equal the FIFO head; both are derived from registers only, with no combinational path from in_*.
REQ-025 Latency: avm_m0_write SHALL rise on the first cycle after the push edge when the FIFO was empty.
REQ-026 While avm_m0_write & avm_m0_waitrequest, writedata SHALL be held stable.
REQ-027 On a cycle with avm_m0_write & !avm_m0_waitrequest, the head SHALL be popped; the next entry (if any) is presented the following cycle, giving back-to-back writes with write held high.
REQ-028 On simultaneous push and pop, both SHALL take effect with occupancy unchanged; push to an empty FIFO plus pop cannot occur.
REQ-029 Commands SHALL leave in arrival order; none are dropped or duplicated.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the full/empty distinction is made with an extra pointer bit or an occupancy counter.

Reset
REQ-031 On a reset edge: parser to IDLE, running status invalid, FIFO emptied, avm_m0_write=0, avm_m0_writedata=0, in_ready=1 on the next cycle.
REQ-032 Reset mid-message or mid-transfer SHALL discard the partial message and all queued commands; an Avalon write stalled by waitrequest is abandoned.

Verification
REQ-033 Bytes 0x90,0x45,0x64, waitrequest=0 -> one write of 0x0000_C564, one cycle after the 0x64 byte is consumed.
REQ-034 Running status: bytes 0x90,0x45,0x64,0x49,0x00 -> writes 0x0000_C564 then 0x0000_4900, in order.
REQ-035 Bytes 0xB0,0x7B,0x00 -> write 0x0000_7F00; bytes 0x90,0xF8,0x45,0x64 -> write 0x0000_C564 (real-time byte ignored); bytes 0x91,0x45,0x64 with CHANNEL=0 -> no write.
REQ-036 waitrequest held high for 30 cycles while 6 note-ons stream in -> in_ready=0 after 4 are queued; writedata stable during the stall; after release, all 6 writes occur in order with no loss.
REQ-037 Bytes 0x90,0x45, then reset, then 0x64 -> no write; then 0x80,0x7F,0x00 -> no write (note-off for note 127 dropped).

Source files
------------

// File: rtl/midi_avalon_bridge.sv
// rtl/midi_avalon_bridge.sv - MIDI byte-stream parser feeding synth commands to an Avalon-MM master
//
// Ports:
//   clk                 single clock, rising edge
//   reset               synchronous active-high reset
//   in_data/in_valid    MIDI byte from the UART receiver
//   in_ready            byte accepted this cycle (high while the command FIFO is not full)
//   avm_m0_write        Avalon write request (high while the command FIFO is not empty)
//   avm_m0_writedata    {16'b0, on, note[6:0], vel[7:0]} taken from the FIFO head
//   avm_m0_waitrequest  slave stall; the head is popped only when this is low
module midi_avalon_bridge #(
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        avm_m0_write,
    output logic [31:0] avm_m0_writedata,
    input  logic        avm_m0_waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;

    state_t      state;
    logic        rs_valid;
    logic [3:0]  rs_type;
    logic        rs_match;
    logic [6:0]  d1;

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic        full_q;
    logic        empty_q;

    logic        accept;
    logic        is_status;
    logic        is_realtime;
    logic        is_system;
    logic        chan_ok;
    logic        two_byte;
    logic        push;
    logic        pop;
    logic [15:0] cmd;
    logic        cmd_ok;

    assign accept      = in_valid & ~full_q;
    assign is_status   = in_data[7];
    assign is_realtime = (in_data[7:3] == 5'b11111);
    assign is_system   = (in_data[7:3] == 5'b11110);
    assign chan_ok     = (OMNI != 0) || (in_data[3:0] == 4'(CHANNEL));
    assign two_byte    = (rs_type != 4'hC) && (rs_type != 4'hD);

    // Command decode for the final data byte of a two-byte message; in_data is d2.
    always_comb begin
        cmd    = 16'h0000;
        cmd_ok = 1'b0;
        case (rs_type)
            4'h8: begin
                cmd    = {1'b0, d1, 1'b0, in_data[6:0]};
                cmd_ok = (d1 != 7'h7F);
            end
            4'h9: begin
                if (in_data[6:0] != 7'h00) begin
                    cmd    = {1'b1, d1, 1'b0, in_data[6:0]};
                    cmd_ok = 1'b1;
                end else begin
                    cmd    = {1'b0, d1, 8'h00};
                    cmd_ok = (d1 != 7'h7F);
                end
            end
            4'hB: begin
                // all-notes-off maps to the synth STOP_ALL pattern (off, note 127)
                cmd    = 16'h7F00;
                cmd_ok = (d1 == 7'd123);
            end
            default: begin
                cmd    = 16'h0000;
                cmd_ok = 1'b0;
            end
        endcase
    end

    assign push = accept & ~is_status & (state == DATA2) & rs_match & cmd_ok;
    assign pop  = ~empty_q & ~avm_m0_waitrequest;

    // Parser: status bytes restart a message from any state; data bytes
    // advance through DATA1/DATA2 and fall back to DATA1 for running status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rs_valid <= 1'b0;
            rs_type  <= 4'h0;
            rs_match <= 1'b0;
            d1       <= 7'h00;
        end else if (accept && !is_realtime) begin
            if (is_system) begin
                rs_valid <= 1'b0;
                state    <= IDLE;
            end else if (is_status) begin
                rs_valid <= 1'b1;
                rs_type  <= in_data[7:4];
                rs_match <= chan_ok;
                state    <= DATA1;
            end else begin
                case (state)
                    IDLE, DATA1: begin
                        if (state == DATA1 || rs_valid) begin
                            if (two_byte) begin
                                d1    <= in_data[6:0];
                                state <= DATA2;
                            end else begin
                                state <= DATA1;
                            end
                        end
                    end
                    DATA2:   state <= DATA1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Full/empty are registered from the next occupancy so in_ready and
    // avm_m0_write never depend combinationally on in_* or waitrequest.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            full_q  <= (count_next == CW'(FIFO_DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd;
    end

    assign in_ready         = ~full_q;
    assign avm_m0_write     = ~empty_q;
    assign avm_m0_writedata = empty_q ? 32'h0000_0000 : {16'h0000, mem[rd_ptr]};

endmodule

// File: tb/tb_midi_avalon_bridge.sv
// tb/tb_midi_avalon_bridge.sv - self-checking bench for midi_avalon_bridge
module tb_midi_avalon_bridge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got[$];

    // model parser state: current status byte (0 = none) and data bytes still needed
    int          m_status = 0;
    int          m_need = 0;
    int          m_d1 = 0;

    midi_avalon_bridge #(.CHANNEL(0), .OMNI(0), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int needed(input int status);
        int kind;
        kind = status / 16;
        return (kind == 12 || kind == 13) ? 1 : 2;
    endfunction

    task automatic model_complete(input int d1, input int d2);
        int kind;
        int ch;
        kind = m_status / 16;
        ch   = m_status % 16;
        if (ch != 0) return;
        if (kind == 9 && d2 > 0)
            exp_q.push_back(32'(32768 + d1 * 256 + d2));
        else if (kind == 8 || kind == 9) begin
            if (d1 != 127) exp_q.push_back(32'(d1 * 256 + d2));
        end else if (kind == 11 && d1 == 123)
            exp_q.push_back(32'h0000_7F00);
    endtask

    task automatic model_byte(input int b);
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            m_status = 0;
            m_need   = 0;
            return;
        end
        if (b >= 'h80) begin
            m_status = b;
            m_need   = needed(b);
            return;
        end
        if (m_status == 0) return;
        if (m_need == 0) m_need = needed(m_status);
        if (m_need == 2) begin
            m_d1   = b;
            m_need = 1;
        end else begin
            m_need = 0;
            if (needed(m_status) == 2) model_complete(m_d1, b);
        end
    endtask

    // model update and observed-write log, on the active edge with pre-edge values
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_status = 0;
            m_need   = 0;
        end else begin
            if (avm_m0_write && !avm_m0_waitrequest) begin
                got.push_back(avm_m0_writedata);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) model_byte(int'(in_data));
        end
    end

    // cycle-by-cycle comparison against the model queue
    always @(negedge clk) begin
        if (!reset) begin
            chk("write_vs_model", 32'(avm_m0_write), 32'(exp_q.size() != 0));
            chk("ready_vs_model", 32'(in_ready), 32'(exp_q.size() < DEPTH));
            if (avm_m0_write && exp_q.size() != 0)
                chk("data_vs_model", avm_m0_writedata, exp_q[0]);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready %0d expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_write", 32'(avm_m0_write), 32'h0);
        chk("reset_data", avm_m0_writedata, 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;

        // single note-on, one-cycle latency
        got.delete();
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        @(negedge clk);
        chk("latency_write", 32'(avm_m0_write), 32'h1);
        chk("latency_data", avm_m0_writedata, 32'h0000_C564);
        idle(4);
        chk("single_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("single_val", got[0], 32'h0000_C564);

        // running status note-on then note-on vel 0
        got.delete();
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        send_byte(8'h49); send_byte(8'h00);
        idle(4);
        chk("rs_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("rs_first", got[0], 32'h0000_C564);
            chk("rs_second", got[1], 32'h0000_4900);
        end

        // all notes off, real-time interleave, foreign channel
        got.delete();
        send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h45); send_byte(8'h64);
        send_byte(8'h91); send_byte(8'h45); send_byte(8'h64);
        send_byte(8'hC0); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h07); send_byte(8'h10);
        idle(4);
        chk("mix_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("stop_all", got[0], 32'h0000_7F00);
            chk("rt_ignored", got[1], 32'h0000_C564);
        end

        // stall for 30 cycles while 6 note-ons arrive
        got.delete();
        avm_m0_waitrequest = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_byte(8'h90);
                    send_byte(8'(8'h40 + i));
                    send_byte(8'(8'h10 + i));
                end
            end
            begin
                repeat (30) @(negedge clk);
                chk("stall_ready", 32'(in_ready), 32'h0);
                chk("stall_write", 32'(avm_m0_write), 32'h1);
                chk("stall_data", avm_m0_writedata, 32'h0000_C010);
                @(posedge clk);
                #1 avm_m0_waitrequest = 1'b0;
            end
        join
        idle(8);
        chk("stall_count", 32'(got.size()), 32'd6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("stall_order", got[i], 32'h0000_C010 + 32'(i * 257));
        end

        // reset mid-message, note-off 127 dropped, note-on 127 kept
        got.delete();
        send_byte(8'h90); send_byte(8'h45);
        pulse_reset();
        send_byte(8'h64);
        send_byte(8'h80); send_byte(8'h7F); send_byte(8'h00);
        idle(4);
        chk("reset_drop_count", 32'(got.size()), 32'd0);
        send_byte(8'h90); send_byte(8'h7F); send_byte(8'h01);
        idle(4);
        chk("on127_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("on127_val", got[0], 32'h0000_FF01);

        // reset abandons a stalled write
        avm_m0_waitrequest = 1'b1;
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h10);
        @(negedge clk);
        chk("prestall_write", 32'(avm_m0_write), 32'h1);
        pulse_reset();
        @(negedge clk);
        chk("abandon_write", 32'(avm_m0_write), 32'h0);
        chk("abandon_data", avm_m0_writedata, 32'h0);
        avm_m0_waitrequest = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
